// File: rtl/parity_check_pipe.sv
// Even-parity checker with a one-entry output register plus skid buffer.
// It also keeps a saturating error count and captures the first failing word.
module parity_check_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_vld,
  output logic [DATA_W-1:0] first_err_data
);

  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic              outErr_q, outErr_d;
  logic              skidValid_q, skidValid_d;
  logic [DATA_W-1:0] skidData_q, skidData_d;
  logic              skidErr_q, skidErr_d;
  logic [CNT_W-1:0]  errCnt_q, errCnt_d;
  logic              firstVld_q, firstVld_d;
  logic [DATA_W-1:0] firstData_q, firstData_d;

  logic accept;
  logic inErr;

  assign in_ready = ~skidValid_q;
  assign accept   = in_valid & ~skidValid_q;
  assign inErr    = ^{in_data, in_par};

  // The skid entry always has priority over new input because it is older.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outErr_d    = outErr_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidErr_d   = skidErr_q;
    if (!outValid_q || out_ready) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outData_d   = skidData_q;
        outErr_d    = skidErr_q;
        skidValid_d = 1'b0;
      end else if (accept) begin
        outValid_d = 1'b1;
        outData_d  = in_data;
        outErr_d   = inErr;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidData_d  = in_data;
      skidErr_d   = inErr;
    end
  end

  // Clear is applied before a same-cycle erroring word is counted.
  always_comb begin
    errCnt_d    = clr_err ? '0 : errCnt_q;
    firstVld_d  = clr_err ? 1'b0 : firstVld_q;
    firstData_d = firstData_q;
    if (accept && inErr) begin
      if (errCnt_d != '1) errCnt_d = errCnt_d + CNT_W'(1);
      if (!firstVld_d) begin
        firstVld_d  = 1'b1;
        firstData_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outErr_q    <= 1'b0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidErr_q   <= 1'b0;
      errCnt_q    <= '0;
      firstVld_q  <= 1'b0;
      firstData_q <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outErr_q    <= outErr_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      skidErr_q   <= skidErr_d;
      errCnt_q    <= errCnt_d;
      firstVld_q  <= firstVld_d;
      firstData_q <= firstData_d;
    end
  end

  assign out_valid      = outValid_q;
  assign out_data       = outData_q;
  assign out_err        = outErr_q;
  assign err_cnt        = errCnt_q;
  assign first_err_vld  = firstVld_q;
  assign first_err_data = firstData_q;

endmodule

// File: doc/parity_check_pipe.md
Name: parity_check_pipe

Overview:
Downstream consumer of the even-parity generator. It accepts words tagged with their even-parity bit over a valid/ready handshake and re-checks parity. It forwards each word with a per-word error flag through a one-cycle registered stage with a skid buffer. It also keeps a saturating error count and captures the first failing word for status readout.

Parameters:
DATA_W  32  width of checked data word
CNT_W   16  width of error counter

Ports:
clk             input   1        rising-edge clock
rst_n           input   1        asynchronous active-low reset
in_valid        input   1        upstream word valid
in_ready        output  1        block can accept a word
in_data         input   DATA_W   data word
in_par          input   1        even-parity bit supplied by upstream
out_valid       output  1        downstream word valid
out_ready       input   1        downstream accepts word
out_data        output  DATA_W   forwarded data word
out_err         output  1        1 = parity mismatch on out_data
clr_err         input   1        single-cycle pulse; clears error status
err_cnt         output  CNT_W    accepted words with parity error, saturating
first_err_vld   output  1        first_err_data holds a captured word
first_err_data  output  DATA_W   first failing word since reset or clear

Behaviour:
- Reset: asynchronous assert on rst_n low, synchronous release.
  - Reset values: out_valid=0, out_data=0, out_err=0, err_cnt=0, first_err_vld=0, first_err_data=0.
  - Skid buffer resets empty, so in_ready=1 from the first cycle after reset.
- Check:
  - err = ^{in_data, in_par}. Even parity over DATA_W+1 bits means a correct word gives err=0.
  - err is computed at acceptance (in_valid & in_ready) and stored alongside the data.
- Pipeline:
  - One output register (out_*) plus one skid entry.
  - Accept: data goes to the output register if it is empty or draining this cycle (out_ready=1). Otherwise it goes to the skid entry.
  - Latency: accepted word appears on out_* the next cycle when there is no backpressure.
  - Throughput: one word per cycle when out_ready is held high.
- in_ready:
  - Equals ~skid_valid and is a registered-state function, with no combinational path from out_ready.
  - When the output drains and the skid entry is full, the skid entry moves to the output register in the same cycle and in_ready rises the next cycle.
- Output hold:
  - While out_valid=1 and out_ready=0, out_data and out_err stay stable.
  - out_valid never drops without a transfer.
- Ordering: strict FIFO order. No word is dropped or duplicated.
- Error counter:
  - err_cnt increments by 1 on each accepted word with err=1.
  - It saturates at 2^CNT_W-1 and holds there.
- First-error capture: on an accepted word with err=1 while first_err_vld=0, first_err_data takes in_data and first_err_vld is set.
- Clear:
  - clr_err=1 sets err_cnt=0 and first_err_vld=0; first_err_data keeps its value.
  - If an erroring word is accepted in the same cycle, clear applies first: err_cnt=1, first_err_vld=1, first_err_data=in_data.
- Inputs ignored when in_valid=0: in_data and in_par have no effect.
- Reset mid-operation: buffered words are discarded and status returns to reset values. No partial transfer appears after reset release.

Test Plan:
1. Single words, out_ready=1, one per cycle:
   - 32'h3456_789a par=1, 32'hc464_78ff par=0, 32'hac54_871f par=0, 32'h3faa_a2c8 par=0.
   - Expect out_data in that order, one cycle after each acceptance, with out_err=0 each time and err_cnt=0.
2. Parity errors:
   - 32'h3456_789a par=0, then 32'hc464_78ff par=1.
   - Expect out_err=1 on both and err_cnt=2.
   - Expect first_err_vld=1 and first_err_data=32'h3456_789a.
3. Backpressure:
   - Stream 4 words with out_ready=0.
   - Expect in_ready to drop after 2 acceptances and out_data to hold the first word.
   - Release out_ready: all 4 words emerge in order, with no loss or duplication.
4. Clear collision:
   - With err_cnt=5, assert clr_err in the same cycle as accepting 32'hac54_871f par=1.
   - Expect err_cnt=1 and first_err_data=32'hac54_871f.
5. Saturation:
   - With CNT_W=4, push 17 bad words.
   - Expect err_cnt to stay at 15 from the 15th word onward.
6. Reset mid-stream:
   - Assert rst_n=0 with the skid buffer full.
   - Expect immediate out_valid=0 and err_cnt=0, and in_ready=1 after release.
